// File: rtl/pid_mult_scheduler.sv
// Shares one serial shift-add multiplier between the P, I and D term generators.
// Grants round-robin, runs a fixed 6-step multiply and returns a saturated product with a done pulse.
module pid_mult_scheduler #(
  parameter int unsigned W    = 6,
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  input  logic [W-1:0]    a2,
  input  logic [W-1:0]    b2,
  output logic [W-1:0]    result,
  output logic            sat,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [PW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  last;
  logic [IW-1:0]  gnt_idx;

  logic           gnt_any;
  logic [IW-1:0]  gnt_sel;
  logic [IW-1:0]  idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [PW-1:0]  pp;
  logic [PW-1:0]  acc_next;
  logic           sat_next;

  // Round-robin pick: scanning from far to near lets the nearest index after last win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    idx     = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx = IW'((int'(last) + k) % int'(NREQ));
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_sel = idx;
      end
    end
  end

  always_comb begin
    a_sel = a2;
    b_sel = b2;
    case (gnt_sel)
      IW'(0):  begin a_sel = a0; b_sel = b0; end
      IW'(1):  begin a_sel = a1; b_sel = b1; end
      default: begin a_sel = a2; b_sel = b2; end
    endcase
  end

  // One partial product per RUN step; saturation is judged on the full-width product.
  assign pp       = opb[cnt] ? (PW'(opa) << cnt) : '0;
  assign acc_next = acc + pp;
  assign sat_next = |acc_next[PW-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      cnt     <= '0;
      last    <= LAST_RST;
      gnt_idx <= '0;
      result  <= '0;
      sat     <= 1'b0;
      done    <= '0;
      busy    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            opa     <= a_sel;
            opb     <= b_sel;
            gnt_idx <= gnt_sel;
            last    <= gnt_sel;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            result <= sat_next ? '1 : acc_next[W-1:0];
            sat    <= sat_next;
            done   <= NREQ'(1) << gnt_idx;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_mult_scheduler.sv
// Scoreboard bench for pid_mult_scheduler: expected products are queued at request time
// and compared when a done pulse rises.
module tb_pid_mult_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] req = '0;
  logic [5:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic [5:0] result;
  logic       sat;
  logic [2:0] done;
  logic       busy;

  pid_mult_scheduler #(.W(6), .NREQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .result(result), .sat(sat), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] done;
    logic [5:0] result;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] done_q = '0;
  int checks = 0;
  int errors = 0;
  int rr_last = 2;
  int n, bn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int idx, input int a, input int b);
    exp_t e;
    int   p;
    p = a * b;
    e.done   = 3'(1 << idx);
    e.sat    = (p > 63);
    e.result = (p > 63) ? 6'd63 : 6'(p);
    return e;
  endfunction

  function automatic int rr_pick(input logic [2:0] r, input int lst);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (lst + k) % 3;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic int get_a(input int i);
    return (i == 0) ? int'(a0) : (i == 1) ? int'(a1) : int'(a2);
  endfunction

  function automatic int get_b(input int i);
    return (i == 0) ? int'(b0) : (i == 1) ? int'(b1) : int'(b2);
  endfunction

  // Compare on each rising done; a done with nothing queued is an error.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q = '0;
    end else begin
      if (done != 3'b000 && done_q == 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("sb_done", 32'(done), 32'(mon_e.done));
          check("sb_result", 32'(result), 32'(mon_e.result));
          check("sb_sat", 32'(sat), 32'(mon_e.sat));
        end
      end
      done_q = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cnt, output int busy_cnt);
    cnt = 0;
    busy_cnt = 0;
    do begin
      step();
      cnt++;
      if (busy) busy_cnt++;
    end while (done == 3'b000 && cnt < budget);
  endtask

  // Serve whichever requester the round-robin model predicts; drop its req in the done cycle if masked.
  task automatic serve_next(input logic [2:0] drop_mask);
    int w, lat, bc;
    w = rr_pick(req, rr_last);
    sb.push_back(model(w, get_a(w), get_b(w)));
    wait_done(20, lat, bc);
    check($sformatf("latency_req%0d", w), 32'(lat), 32'(7));
    check($sformatf("busy_cycles_req%0d", w), 32'(bc), 32'(7));
    if (drop_mask[w]) req[w] = 1'b0;
    step();
    rr_last = w;
  endtask

  initial begin
    repeat (3) step();
    check("rst_result", 32'(result), 32'(0));
    check("rst_sat", 32'(sat), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    step();

    // Single P request
    a0 = 6'd5; b0 = 6'd7; req = 3'b001;
    serve_next(3'b111);
    check("t1_busy_after", 32'(busy), 32'(0));
    check("t1_done_after", 32'(done), 32'(0));
    check("t1_result_held", 32'(result), 32'(35));

    // Saturation on I
    a1 = 6'd20; b1 = 6'd10; req = 3'b010;
    serve_next(3'b111);
    check("t2_sat_held", 32'(sat), 32'(1));

    // Operand change and req drop during RUN
    a2 = 6'd3; b2 = 6'd3; req = 3'b100;
    sb.push_back(model(2, 3, 3));
    repeat (4) step();
    a2 = 6'd63; req = 3'b000;
    wait_done(20, n, bn);
    check("t4_latency", 32'(n), 32'(3));
    step();
    rr_last = 2;
    check("t4_idle", 32'(busy), 32'(0));

    // Full contention, each requester drops in its own done cycle
    a0 = 6'd2; b0 = 6'd3; a1 = 6'd4; b1 = 6'd5; a2 = 6'd9; b2 = 6'd9;
    req = 3'b111;
    repeat (3) serve_next(3'b111);
    req = 3'b111;
    serve_next(3'b111);
    check("t3_first_again_last", 32'(rr_last), 32'(0));
    req = 3'b000;
    step();

    // Requester 2 never drops; 0 and 1 re-raise after being served
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve_next(3'b011);
      if (req[1:0] == 2'b00) req[1:0] = 2'b11;
    end
    req = 3'b000;
    step();
    step();

    // ena stall in RUN and in DONE
    a0 = 6'd9; b0 = 6'd6; req = 3'b001;
    sb.push_back(model(0, 9, 6));
    step(); step();
    ena = 1'b0;
    repeat (4) step();
    ena = 1'b1;
    wait_done(30, n, bn);
    check("t5_stall_latency", 32'(n), 32'(5));
    ena = 1'b0;
    repeat (3) step();
    check("t5_done_held", 32'(done), 32'(1));
    check("t5_result_held", 32'(result), 32'(54));
    ena = 1'b1;
    req = 3'b000;
    step();
    check("t5_done_clear", 32'(done), 32'(0));
    rr_last = 0;

    // Asynchronous reset during RUN
    a0 = 6'd7; b0 = 6'd7; req = 3'b001;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("t6_result", 32'(result), 32'(0));
    check("t6_sat", 32'(sat), 32'(0));
    check("t6_done", 32'(done), 32'(0));
    check("t6_busy", 32'(busy), 32'(0));
    req = 3'b000;
    #1 rst_n = 1'b1;
    rr_last = 2;
    repeat (10) step();
    check("t6_no_done", 32'(done), 32'(0));
    a1 = 6'd1; b1 = 6'd1; a2 = 6'd1; b2 = 6'd2;
    req = 3'b111;
    serve_next(3'b111);
    check("t6_p_first", 32'(rr_last), 32'(0));
    req = 3'b000;
    repeat (3) step();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_mult_scheduler.md
# pid_mult_scheduler

Time-multiplexes one serial 6x6 shift-add multiplier between the three PID term generators (P, I, D), so the controller pays for a single multiplier datapath. Each term block raises a request with its operands, the scheduler grants round-robin, runs a fixed-latency 6-step multiply, and returns a saturated 6-bit product with a one-cycle done pulse to the granted requester. It sits between the term generators and the PID output summer.

## Interface

Parameters:
- W, 6, operand and result width. The design and test plan are specified for 6 only.
- NREQ, 3, number of requesters; index 0 = P, 1 = I, 2 = D.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable. Low freezes every register.
- req  in  3  level request per requester.
- a0, b0  in  6 each  P operands: error and K_p.
- a1, b1  in  6 each  I operands.
- a2, b2  in  6 each  D operands.
- result  out  6  saturated unsigned product of the last completed operation.
- sat  out  1  high when `result` was clamped. Valid with `result`.
- done  out  3  one-hot, one-cycle completion pulse to the served requester.
- busy  out  1  high in RUN and DONE.

## Operation

- **Reset values:** state = IDLE; `result`, `sat`, `done` and `busy` all 0; accumulator and step counter 0; round-robin pointer `last` = 2, so P wins the first contention.
- **Asynchronous reset mid-operation:** aborts the operation. No done pulse is issued and all registers return to their reset values.
- **ena = 0:** state, counter, accumulator, pointer and outputs hold. An already-asserted `done` stays high until ena returns and the next edge advances the FSM.

State machine (advances only when ena = 1):
- **IDLE:** if any `req` bit is set, grant one requester:
  - Search order starts at index `last`+1 mod 3 and wraps.
  - On that edge: capture the granted a/b into internal `opa`/`opb`, set `gnt_idx`, set `last` to `gnt_idx`, clear the 12-bit accumulator and the step counter, then go to RUN.
  - No request: stay in IDLE.
- **RUN:** exactly 6 edges, one per bit.
  - If `opb[cnt]` = 1, the accumulator adds (`opa` << `cnt`).
  - `cnt` increments each edge.
  - On the edge where `cnt` = 5, go to DONE. On that same edge:
    - `result` <= min(final product, 63);
    - `sat` <= (product > 63);
    - `done[gnt_idx]` <= 1.
- **DONE:** one cycle. On the next edge clear `done` and go to IDLE.

Arithmetic and requester rules:
- **Arithmetic:** unsigned, with a 12-bit internal product. Saturation applies only at the output.
- **Fixed latency:** a = 0 or b = 0 still takes the full 6 RUN cycles.
- **Operand stability:** operands are sampled only at the grant edge. Later changes, or `req` dropping during RUN, do not affect the operation, and done is still issued.
- **Requests are level-sensitive:** a requester must drop `req` in the cycle `done` is high, i.e. before the DONE->IDLE edge. A `req` still high at the following IDLE edge counts as a new request.
- **Held outputs:** `result` and `sat` hold until the next DONE load.
- **`busy`** = (state != IDLE).

## Timing

- Grant edge E0 -> RUN edges E1..E6 -> `done`/`result` visible after E6 -> DONE->IDLE at E7 -> next grant possible at E8.
- Latency from grant edge to `done` high: 6 cycles.
- Throughput: one multiply per 8 cycles (with ena = 1).
- All outputs are registered; there is no combinational path from req or operands to any output.
- Simultaneous requests are served in round-robin order, with no starvation. With all three requests held, the order is 0, 1, 2, 0, …

## Test plan

- **Reset then single request:** reset, then req = 3'b001 with a0 = 5, b0 = 7. Required response: done = 3'b001 exactly 6 cycles after the grant edge, result = 35, sat = 0, busy high for 7 cycles.
- **Saturation:** req[1] with a1 = 20, b1 = 10. Required response: result = 63, sat = 1, done = 3'b010.
- **Full contention:** req = 3'b111 held, with each requester dropping its bit in its own done cycle. Required response: done order 001, 010, 100 at 8-cycle spacing; then re-raising all three gives 001 first again. A variant where requester 2 never drops its request shows 0 and 1 still served between repeated 2 grants.
- **Operand change and req drop mid-RUN:** grant at a2 = 3, b2 = 3, then change a2 to 63 and drop req[2] at RUN cycle 3. Required response: result = 9, done = 3'b100.
- **ena stall:** hold ena low for 4 cycles during RUN. Required response: done arrives exactly 4 cycles late with the correct product; with ena low during DONE, the done pulse lengthens to match.
- **Reset mid-RUN:** pulse rst_n low at RUN cycle 2. Required response: all outputs 0 immediately and no done pulse; the next request is served normally, with P winning any contention.
